// File: rtl/onehot_updown_counter.sv
// onehot_updown_counter
// Bidirectional one-hot ring counter. It steps a single set bit left (up) or
// right (down) around an N-bit ring. It also provides a synchronous load, a
// binary index of the set bit, a wrap pulse and an out-of-range load pulse.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   enable     in   advance one step this cycle when high
//   up         in   1 = step bit i to bit i+1, 0 = step bit i to bit i-1
//   load       in   synchronous load of load_index (wins over enable)
//   load_index in   IW-bit target index for load
//   Q          out  N-bit one-hot state, registered
//   index      out  IW-bit binary index of the set bit in Q, registered
//   wrap       out  one-cycle pulse after an N-1 -> 0 (up) or 0 -> N-1 (down) step
//   load_err   out  one-cycle pulse after a load with load_index >= N
module onehot_updown_counter #(
  parameter int N    = 3,
  parameter int IW   = 2,
  parameter int INIT = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          up,
  input  logic          load,
  input  logic [IW-1:0] load_index,
  output logic [N-1:0]  Q,
  output logic [IW-1:0] index,
  output logic          wrap,
  output logic          load_err
);

  // N is carried one bit wider than the index so load_index >= N compares cleanly.
  localparam logic [IW:0]   N_L    = (IW+1)'(N);
  localparam logic [IW-1:0] LAST_L = IW'(N - 1);
  localparam logic [IW-1:0] INIT_L = IW'(INIT);
  localparam logic [IW-1:0] ZERO_L = {IW{1'b0}};

  // Decode a binary index into its one-hot pattern.
  function automatic logic [N-1:0] onehot_f(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      v[k] = (int'(idx) == k);
    end
    return v;
  endfunction

  logic [N-1:0]  q_r;
  logic [IW-1:0] index_r;
  logic          wrap_r;
  logic          load_err_r;

  logic [N-1:0]  q_next_s;
  logic [IW-1:0] index_next_s;
  logic          wrap_next_s;
  logic          load_err_next_s;
  logic          load_ok_s;

  assign load_ok_s = ({1'b0, load_index} < N_L);

  // Next-state selection: load beats enable, and enable steps in the sampled direction.
  always_comb begin
    q_next_s        = q_r;
    index_next_s    = index_r;
    wrap_next_s     = 1'b0;
    load_err_next_s = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        q_next_s     = onehot_f(load_index);
        index_next_s = load_index;
      end else begin
        q_next_s        = onehot_f(ZERO_L);
        index_next_s    = ZERO_L;
        load_err_next_s = 1'b1;
      end
    end else if (enable) begin
      case (up)
        1'b1: begin
          // Rotate left; bit N-1 comes round to bit 0.
          q_next_s = {q_r[N-2:0], q_r[N-1]};
          if (index_r == LAST_L) begin
            index_next_s = ZERO_L;
            wrap_next_s  = 1'b1;
          end else begin
            index_next_s = index_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        1'b0: begin
          // Rotate right; bit 0 comes round to bit N-1.
          q_next_s = {q_r[0], q_r[N-1:1]};
          if (index_r == ZERO_L) begin
            index_next_s = LAST_L;
            wrap_next_s  = 1'b1;
          end else begin
            index_next_s = index_r - {{(IW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          q_next_s     = q_r;
          index_next_s = index_r;
        end
      endcase
    end else begin
      q_next_s     = q_r;
      index_next_s = index_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q_r        <= onehot_f(INIT_L);
      index_r    <= INIT_L;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_next_s;
      index_r    <= index_next_s;
      wrap_r     <= wrap_next_s;
      load_err_r <= load_err_next_s;
    end
  end

  assign Q        = q_r;
  assign index    = index_r;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_onehot_updown_counter.sv
// Self-checking bench for onehot_updown_counter (N=3, IW=2, INIT=0).
// The reference model tracks only an integer position and uses modulo arithmetic.
module tb_onehot_updown_counter;

  localparam int N    = 3;
  localparam int IW   = 2;
  localparam int INIT = 0;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          up;
  logic          load;
  logic [IW-1:0] load_index;
  logic [N-1:0]  Q;
  logic [IW-1:0] index;
  logic          wrap;
  logic          load_err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_pos;
  int m_wrap;
  int m_err;

  onehot_updown_counter #(.N(N), .IW(IW), .INIT(INIT)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_index (load_index),
    .Q          (Q),
    .index      (index),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare all outputs.
  task automatic step(input logic rst_n, input logic en, input logic u,
                      input logic ld, input int li);
    reset      = rst_n;
    enable     = en;
    up         = u;
    load       = ld;
    load_index = IW'(li);
    @(posedge clock);
    #1;
    if (!rst_n) begin
      m_pos = INIT; m_wrap = 0; m_err = 0;
    end else if (ld) begin
      m_wrap = 0;
      if (li < N) begin m_pos = li; m_err = 0; end
      else begin m_pos = 0; m_err = 1; end
    end else if (en) begin
      m_err = 0;
      if (u) begin
        m_wrap = (m_pos == N - 1);
        m_pos  = (m_pos + 1) % N;
      end else begin
        m_wrap = (m_pos == 0);
        m_pos  = (m_pos + N - 1) % N;
      end
    end else begin
      m_wrap = 0; m_err = 0;
    end
    check_value("Q",        32'(Q),        32'(1) << m_pos);
    check_value("index",    32'(index),    32'(m_pos));
    check_value("wrap",     32'(wrap),     32'(m_wrap));
    check_value("load_err", 32'(load_err), 32'(m_err));
  endtask

  initial begin
    logic [N-1:0] up_seq [4];
    logic [N-1:0] dn_seq [4];
    logic         up_wrp [4];
    logic         dn_wrp [4];
    up_seq = '{3'b010, 3'b100, 3'b001, 3'b010};
    up_wrp = '{1'b0,   1'b0,   1'b1,   1'b0};
    dn_seq = '{3'b100, 3'b010, 3'b001, 3'b100};
    dn_wrp = '{1'b1,   1'b0,   1'b0,   1'b1};
    m_pos = 0; m_wrap = 0; m_err = 0;

    // Reset first.
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_value("rst_Q", 32'(Q), 32'h1);

    // Up count from 001, also against the literal sequence.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 0);
      check_value("up_seq",  32'(Q),    32'(up_seq[i]));
      check_value("up_wrap", 32'(wrap), 32'(up_wrp[i]));
    end

    // Back to 001, then down count.
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      check_value("dn_seq",  32'(Q),    32'(dn_seq[i]));
      check_value("dn_wrap", 32'(wrap), 32'(dn_wrp[i]));
    end

    // Load with enable: no step; then out-of-range load.
    step(1'b1, 1'b1, 1'b1, 1'b1, 2);
    check_value("ld2_Q", 32'(Q), 32'h4);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3);
    check_value("ld3_err", 32'(load_err), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0);
    check_value("err_pulse", 32'(load_err), 32'h0);

    // Direction flip from index 1, then hold.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check_value("flip_up", 32'(index), 32'h2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check_value("flip_dn", 32'(index), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'(i), 1'b0, 0);
      check_value("hold", 32'(index), 32'h1);
    end

    // Reset on the same edge as load and enable at index 2.
    step(1'b1, 1'b0, 1'b0, 1'b1, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1);
    check_value("rst_mid_Q", 32'(Q), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, (1 << IW) - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
